fifo_to_stream: RTL and testbench

FIFO_TO_STREAM -- requirements
Module: fifo_to_stream

---
 rtl/fifo_to_stream.sv | 138 +++++++++++++
 tb/tb_fifo_to_stream.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_to_stream.sv
// Drains LEN words from a registered-read upstream fifo onto an AXI-stream style master port.
// A two-entry skid buffer absorbs the one-cycle read latency so full throughput survives backpressure.
module fifo_to_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  START,
   input  logic [LEN_WIDTH-1:0]  LEN,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  FIFO_RD_CMD,
   input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
   input  logic                  FIFO_EMPTY,
   output logic                  M_TVALID,
   input  logic                  M_TREADY,
   output logic [DATA_WIDTH-1:0] M_TDATA,
   output logic                  M_TLAST
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_busy;
   logic                  r_done;
   logic [LEN_WIDTH-1:0]  r_rd_rem;
   logic [LEN_WIDTH-1:0]  r_wr_rem;
   logic [1:0]            r_occ;
   logic                  r_inflight;
   logic [DATA_WIDTH-1:0] r_skid0;
   logic [DATA_WIDTH-1:0] r_skid1;

   logic                  w_pop;
   logic                  w_push;
   logic                  w_accept;
   logic [1:0]            w_level;

   assign M_TVALID = (r_occ != 2'd0);
   assign M_TDATA  = r_skid0;
   assign M_TLAST  = M_TVALID & (r_wr_rem == LEN_WIDTH'(1));
   assign BUSY     = r_busy;
   assign DONE     = r_done;

   assign w_pop    = M_TVALID & M_TREADY;
   assign w_push   = r_inflight;
   assign w_accept = (r_state == IDLE) & START & (LEN != '0);

   // Buffer occupancy after this edge; a new read is only legal if its word will still fit.
   assign w_level  = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

   assign FIFO_RD_CMD = (r_state == RUN) & ~FIFO_EMPTY & (r_rd_rem != '0) & (w_level < 2'd2);

   // NOTE: non-blocking assignments so every register here samples the pre-edge values of the others.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (START) begin
                  r_busy <= 1'b1;
                  if (LEN == '0) begin
                     r_state <= FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               if (w_pop && M_TLAST) begin
                  r_state <= FIN;
                  r_done  <= 1'b1;
               end
            end
            FIN: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: the skid registers are reset too, because M_TDATA is read straight from skid0 and must be 0 in reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_rd_rem   <= '0;
         r_wr_rem   <= '0;
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
         r_skid0    <= '0;
         r_skid1    <= '0;
      end else begin
         r_inflight <= FIFO_RD_CMD;
         r_occ      <= w_level;

         if (w_accept) begin
            r_rd_rem <= LEN;
            r_wr_rem <= LEN;
         end else begin
            if (FIFO_RD_CMD) r_rd_rem <= r_rd_rem - LEN_WIDTH'(1);
            if (w_pop)       r_wr_rem <= r_wr_rem - LEN_WIDTH'(1);
         end

         case ({w_push, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_skid0 <= FIFO_RD_DATA;
               else               r_skid1 <= FIFO_RD_DATA;
            end
            2'b01: begin
               r_skid0 <= r_skid1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_skid0 <= FIFO_RD_DATA;
               end else begin
                  r_skid0 <= r_skid1;
                  r_skid1 <= FIFO_RD_DATA;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_to_stream.sv
// Self-checking bench for fifo_to_stream: an upstream fifo model feeds a scoreboard of loaded words,
// and a negedge monitor compares every accepted beat against it.
module tb_fifo_to_stream;

   localparam int DW = 32;
   localparam int LW = 16;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          START;
   logic [LW-1:0] LEN;
   logic          BUSY;
   logic          DONE;
   logic          FIFO_RD_CMD;
   logic [DW-1:0] FIFO_RD_DATA = '0;
   logic          FIFO_EMPTY;
   logic          M_TVALID;
   logic          M_TREADY = 1'b1;
   logic [DW-1:0] M_TDATA;
   logic          M_TLAST;

   int n_checks = 0;
   int n_errors = 0;

   // Upstream fifo model: pushes from the stimulus, registered reads, flushed by the shared reset.
   logic [DW-1:0] mem [0:63];
   int push_cnt = 0;
   int pop_cnt  = 0;
   int rd_cnt   = 0;
   assign FIFO_EMPTY = (push_cnt == pop_cnt);

   logic [DW-1:0] exp_q [$];
   int  cur_len     = 0;
   int  beat_idx    = 0;
   int  rd_base     = 0;
   bit  bubble_seen = 0;
   bit  prev_stall  = 0;
   logic [DW-1:0] prev_data = '0;
   logic prev_last = 1'b0;
   int  ready_mode = 0;
   int  phase      = 0;

   fifo_to_stream #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .START        (START),
      .LEN          (LEN),
      .BUSY         (BUSY),
      .DONE         (DONE),
      .FIFO_RD_CMD  (FIFO_RD_CMD),
      .FIFO_RD_DATA (FIFO_RD_DATA),
      .FIFO_EMPTY   (FIFO_EMPTY),
      .M_TVALID     (M_TVALID),
      .M_TREADY     (M_TREADY),
      .M_TDATA      (M_TDATA),
      .M_TLAST      (M_TLAST)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge CLK) begin
      if (RESET) begin
         pop_cnt <= push_cnt;
      end else if (FIFO_RD_CMD) begin
         FIFO_RD_DATA <= mem[pop_cnt % 64];
         pop_cnt      <= pop_cnt + 1;
         rd_cnt       <= rd_cnt + 1;
      end
   end

   always @(posedge CLK) begin
      #1;
      phase = phase + 1;
      case (ready_mode)
         1:       M_TREADY = ((phase % 3) == 0);
         default: M_TREADY = 1'b1;
      endcase
   end

   always @(negedge CLK) begin
      if (RESET) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", M_TVALID, 1'b1);
            check("stall_data", M_TDATA, prev_data);
            check("stall_last", M_TLAST, prev_last);
         end
         if (BUSY) check("outstanding_le2", ((rd_cnt - rd_base) - beat_idx) <= 2, 1'b1);
         if (FIFO_RD_CMD) check("rd_while_empty", FIFO_EMPTY, 1'b0);
         if (BUSY && beat_idx > 0 && beat_idx < cur_len && !M_TVALID) bubble_seen = 1;
         if (M_TVALID && M_TREADY) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 1'b1, 1'b0);
            end else begin
               logic [DW-1:0] exp_d;
               exp_d = exp_q.pop_front();
               check("tdata", M_TDATA, exp_d);
            end
            check("tlast", M_TLAST, beat_idx == cur_len - 1);
            beat_idx++;
         end else if (!M_TVALID) begin
            check("tlast_idle", M_TLAST, 1'b0);
         end
         prev_stall = M_TVALID && !M_TREADY;
         prev_data  = M_TDATA;
         prev_last  = M_TLAST;
      end
   end

   task automatic load(input logic [DW-1:0] word);
      mem[push_cnt % 64] = word;
      push_cnt = push_cnt + 1;
      exp_q.push_back(word);
   endtask

   // Returns just after the edge that samples START.
   task automatic start_xfer(input int len);
      @(posedge CLK); #1;
      START       = 1'b1;
      LEN         = LW'(len);
      cur_len     = len;
      beat_idx    = 0;
      bubble_seen = 0;
      rd_base     = rd_cnt;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge CLK);
         if (DONE) seen = 1;
      end
      check(tag, seen, 1'b1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, BUSY, 1'b0);
      check({tag, "_done"}, DONE, 1'b0);
      check({tag, "_rdcmd"}, FIFO_RD_CMD, 1'b0);
      check({tag, "_tvalid"}, M_TVALID, 1'b0);
      check({tag, "_tlast"}, M_TLAST, 1'b0);
      check({tag, "_tdata"}, M_TDATA, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESET = 1'b1;
      START = 1'b0;
      LEN   = '0;
      repeat (2) @(negedge CLK);
      check_outputs_zero("reset");
      @(posedge CLK); #1;
      RESET = 1'b0;

      // LEN=4, preloaded fifo, consumer always ready.
      load(32'h11); load(32'h22); load(32'h33); load(32'h44);
      start_xfer(4);
      @(negedge CLK); check("t1_lat1_valid", M_TVALID, 1'b0);
      @(negedge CLK); check("t1_lat2_valid", M_TVALID, 1'b0);
      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
         check("t1_beat_valid", M_TVALID, 1'b1);
         check("t1_beat_last", M_TLAST, i == 3);
         check("t1_done_low", DONE, 1'b0);
         @(negedge CLK);
      end
      check("t1_done", DONE, 1'b1);
      check("t1_valid_after", M_TVALID, 1'b0);
      @(negedge CLK);
      check("t1_done_pulse", DONE, 1'b0);
      check("t1_idle", BUSY, 1'b0);
      check("t1_reads", rd_cnt - rd_base, 4);
      check("t1_beats", beat_idx, 4);

      // LEN=8 with ready toggling 1,0,0.
      for (int i = 0; i < 8; i++) load(DW'(32'hA0 + i));
      ready_mode = 1;
      start_xfer(8);
      wait_done("t2_done", 100);
      ready_mode = 0;
      check("t2_reads", rd_cnt - rd_base, 8);
      check("t2_beats", beat_idx, 8);
      check("t2_sb_empty", exp_q.size(), 0);

      // LEN=3 with the fifo running dry after one word.
      load(32'hB0);
      start_xfer(3);
      repeat (5) @(posedge CLK);
      #1;
      load(32'hB1); load(32'hB2);
      wait_done("t3_done", 100);
      check("t3_bubble", bubble_seen, 1'b1);
      check("t3_reads", rd_cnt - rd_base, 3);
      check("t3_beats", beat_idx, 3);

      // LEN=0.
      start_xfer(0);
      @(negedge CLK);
      check("t4_busy", BUSY, 1'b1);
      check("t4_done", DONE, 1'b1);
      check("t4_valid", M_TVALID, 1'b0);
      @(negedge CLK);
      check("t4_busy_end", BUSY, 1'b0);
      check("t4_done_end", DONE, 1'b0);
      check("t4_reads", rd_cnt - rd_base, 0);
      check("t4_beats", beat_idx, 0);

      // START re-pulsed during RUN; two words stay behind in the fifo.
      for (int i = 0; i < 5; i++) load(DW'(32'hC0 + i));
      start_xfer(3);
      @(posedge CLK); #1;
      START = 1'b1;
      LEN   = LW'(5);
      @(posedge CLK); #1;
      START = 1'b0;
      wait_done("t5_done", 100);
      check("t5_reads", rd_cnt - rd_base, 3);
      check("t5_beats", beat_idx, 3);
      check("t5_leftover", exp_q.size(), 2);

      // LEN=6 aborted by reset after two beats, then a clean LEN=2.
      for (int i = 0; i < 6; i++) load(DW'(32'hD0 + i));
      start_xfer(6);
      for (int i = 0; i < 50 && beat_idx < 2; i++) begin
         @(posedge CLK); #1;
      end
      check("t6_two_beats", beat_idx, 2);
      RESET = 1'b1;
      #1;
      check_outputs_zero("t6_abort");
      exp_q.delete();
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      load(32'hE0); load(32'hE1);
      start_xfer(2);
      wait_done("t6_done", 100);
      check("t6_reads", rd_cnt - rd_base, 2);
      check("t6_beats", beat_idx, 2);
      check("t6_sb_empty", exp_q.size(), 0);

      repeat (2) @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
